// File: rtl/axi_ic_pkg.sv
// Shared interconnect types and constants: arbiter state encoding and perf counter width.
package axi_ic_pkg;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  localparam int unsigned PERF_CNT_W = 16;

endpackage

// File: rtl/rr_pick.sv
// Combinational rotate-priority picker: first requester at or above ptr, wrapping to 0.
// Shared by the W-channel burst arbiter and AR/AW arbitration.
module rr_pick #(
  parameter int unsigned NUM_SRC = 4,
  parameter int unsigned ID_W    = 2
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [ID_W-1:0]    gnt_id,
  output logic               gnt_vld
);

  logic [ID_W:0]   sum;
  logic [ID_W-1:0] idx;

  // Modulo done by single conditional subtract so non-power-of-two NUM_SRC works.
  always_comb begin
    gnt_id  = '0;
    gnt_vld = 1'b0;
    sum     = '0;
    idx     = '0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      sum = (ID_W+1)'(ptr) + (ID_W+1)'(k);
      if (sum >= (ID_W+1)'(NUM_SRC)) begin
        sum = sum - (ID_W+1)'(NUM_SRC);
      end
      idx = sum[ID_W-1:0];
      if (!gnt_vld && req[idx]) begin
        gnt_vld = 1'b1;
        gnt_id  = idx;
      end
    end
  end

endmodule

// File: rtl/axi_rr_burst_arbiter.sv
// N-to-1 round-robin arbiter with burst lock and one registered output stage.
// Optional per-source burst counters under macro ARB_PERF_CNT_EN.
module axi_rr_burst_arbiter
  import axi_ic_pkg::*;
#(
  parameter int unsigned NUM_SRC    = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ID_W       = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] src_data_i,
  input  logic [NUM_SRC-1:0]            src_last_i,
  input  logic [NUM_SRC-1:0]            src_valid_i,
  output logic [NUM_SRC-1:0]            src_ready_o,
  output logic [DATA_WIDTH-1:0]         dst_data_o,
  output logic                          dst_last_o,
  output logic [ID_W-1:0]               dst_id_o,
  output logic                          dst_valid_o,
  input  logic                          dst_ready_i
`ifdef ARB_PERF_CNT_EN
  ,
  input  logic                          perf_clr_i,
  output logic [NUM_SRC*PERF_CNT_W-1:0] perf_cnt_o
`endif
);

  arb_state_e      state_q, state_d;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0] lock_id_q, lock_id_d;
  logic [ID_W-1:0] pick_id, sel_id;
  logic [ID_W:0]   sel_inc;
  logic            pick_vld, sel_en, out_free, accept;

  logic [DATA_WIDTH-1:0] src_data [NUM_SRC];

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_unpack
    assign src_data[i] = src_data_i[i*DATA_WIDTH +: DATA_WIDTH];
  end

  rr_pick #(
    .NUM_SRC (NUM_SRC),
    .ID_W    (ID_W)
  ) u_pick (
    .req     (src_valid_i),
    .ptr     (rr_ptr_q),
    .gnt_id  (pick_id),
    .gnt_vld (pick_vld)
  );

  assign out_free = ~dst_valid_o | dst_ready_i;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ARB_IDLE;
      rr_ptr_q  <= '0;
      lock_id_q <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      lock_id_q <= lock_id_d;
    end
  end

  // A locked source keeps its ready asserted even while its valid is low.
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    lock_id_d = lock_id_q;
    sel_id    = pick_id;
    sel_en    = pick_vld;
    case (state_q)
      ARB_IDLE: begin
        sel_id = pick_id;
        sel_en = pick_vld;
      end
      ARB_LOCKED: begin
        sel_id = lock_id_q;
        sel_en = 1'b1;
      end
      default: ;
    endcase
    accept  = sel_en & out_free & rst_n & src_valid_i[sel_id];
    sel_inc = (ID_W+1)'(sel_id) + (ID_W+1)'(1);
    if (accept) begin
      if (src_last_i[sel_id]) begin
        state_d  = ARB_IDLE;
        rr_ptr_d = (sel_inc == (ID_W+1)'(NUM_SRC)) ? '0 : sel_inc[ID_W-1:0];
      end else begin
        state_d   = ARB_LOCKED;
        lock_id_d = sel_id;
      end
    end
  end

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_ready
    assign src_ready_o[i] = sel_en & out_free & rst_n & (sel_id == ID_W'(i));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dst_valid_o <= 1'b0;
    end else if (accept) begin
      dst_valid_o <= 1'b1;
    end else if (dst_ready_i) begin
      dst_valid_o <= 1'b0;
    end
  end

  // Payload is don't-care while invalid, so it carries no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      dst_data_o <= src_data[sel_id];
      dst_last_o <= src_last_i[sel_id];
      dst_id_o   <= sel_id;
    end
  end

`ifdef ARB_PERF_CNT_EN
  logic                  accept_last;
  logic [PERF_CNT_W-1:0] perf_cnt_q [NUM_SRC];

  assign accept_last = accept & src_last_i[sel_id];

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_perf
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        perf_cnt_q[i] <= '0;
      end else if (perf_clr_i) begin
        perf_cnt_q[i] <= '0;
      end else if (accept_last && (sel_id == ID_W'(i)) && (perf_cnt_q[i] != '1)) begin
        perf_cnt_q[i] <= perf_cnt_q[i] + PERF_CNT_W'(1);
      end
    end
    assign perf_cnt_o[i*PERF_CNT_W +: PERF_CNT_W] = perf_cnt_q[i];
  end
`endif

endmodule
